// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the branch unit slice.
// Contents:
//   - CPU_AW, CPU_RAS_DEPTH, CPU_INT_DEPTH : default widths and depths
//   - PNZ_P, PNZ_N, PNZ_Z                  : bit positions within a PNZ flag vector
//   - pnz_hit()                            : condition-mask match against flags
package cpu_pkg;

    localparam int CPU_AW        = 16;
    localparam int CPU_RAS_DEPTH = 8;
    localparam int CPU_INT_DEPTH = 4;

    localparam int PNZ_P = 2;
    localparam int PNZ_N = 1;
    localparam int PNZ_Z = 0;

    // A conditional branch is taken when any flag selected by the mask is set.
    function automatic logic pnz_hit(input logic [2:0] mask, input logic [2:0] flags);
        return (mask[PNZ_P] & flags[PNZ_P]) |
               (mask[PNZ_N] & flags[PNZ_N]) |
               (mask[PNZ_Z] & flags[PNZ_Z]);
    endfunction

endpackage

// File: rtl/addr_stack.sv
// Parametrised LIFO of addresses with a saturating occupancy count.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset of pointer and count (entries are not reset)
//   push : write din at the pointer and advance it
//   pop  : retreat the pointer (ignored when empty or when push is also high)
//   din  : address to push
//   top  : most recently pushed entry
//   cnt  : number of valid entries, 0..DEPTH
// WRAP=1: a push when full overwrites the oldest entry (circular buffer).
// WRAP=0: a push when full is ignored; the caller is expected to gate it.
module addr_stack #(
    parameter int AW    = 16,
    parameter int DEPTH = 8,
    parameter bit WRAP  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                din,
    output logic [AW-1:0]                top,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_ptr_inc;
    logic [PW-1:0] w_ptr_dec;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_push  = push & (WRAP | ~w_full);
    assign w_pop   = pop & ~push & ~w_empty;

    // Pointer moves modulo DEPTH so non-power-of-two depths wrap correctly.
    assign w_ptr_inc = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
    assign w_ptr_dec = (r_ptr == '0) ? PW'(DEPTH - 1) : r_ptr - PW'(1);

    assign top = r_mem[w_ptr_dec];
    assign cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_push) begin
            r_ptr <= w_ptr_inc;
            if (!w_full) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (w_pop) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_ptr] <= din;
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: conditional branches on registered PNZ flags,
// call/return via a circular return-address stack, and nested interrupt
// entry/exit via a saturating interrupt stack. No internal pipeline.
// Ports:
//   clk          : clock
//   rst_n        : synchronous reset, ACTIVE-HIGH despite the name
//   pc, target   : execute-stage PC and computed branch target
//   br, cond     : conditional branch and its PNZ mask
//   flag_we      : load pnz_in into the flags register
//   call, ret    : subroutine call / return (subroutine or interrupt)
//   int_in       : interrupt request
//   err_clr      : clear sticky error flags
//   branch_addr  : redirect address
//   branch_taken : redirect valid
//   int_ack      : interrupt accepted this cycle
//   int_level    : current interrupt nesting depth
//   ras_cnt      : return-stack occupancy
//   ras_ovf, ras_unf, int_ovf : sticky error flags
module branch_unit
    import cpu_pkg::*;
#(
    parameter int AW        = CPU_AW,
    parameter int RAS_DEPTH = CPU_RAS_DEPTH,
    parameter int INT_DEPTH = CPU_INT_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [AW-1:0]                    pc,
    input  logic [AW-1:0]                    target,
    input  logic                             br,
    input  logic [2:0]                       cond,
    input  logic                             flag_we,
    input  logic [2:0]                       pnz_in,
    input  logic                             call,
    input  logic                             ret,
    input  logic                             int_in,
    input  logic                             err_clr,
    output logic [AW-1:0]                    branch_addr,
    output logic                             branch_taken,
    output logic                             int_ack,
    output logic [$clog2(INT_DEPTH+1)-1:0]   int_level,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_cnt,
    output logic                             ras_ovf,
    output logic                             ras_unf,
    output logic                             int_ovf
);

    localparam int LW = $clog2(INT_DEPTH + 1);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [2:0]    r_flags;
    logic          r_ras_ovf;
    logic          r_ras_unf;
    logic          r_int_ovf;

    logic          w_int_ack;
    logic          w_int_full;
    logic          w_int_nz;
    logic          w_ret_ok;
    logic          w_taken;
    logic          w_ras_push;
    logic          w_ras_pop;
    logic          w_int_pop;
    logic          w_ras_ovf_set;
    logic          w_ras_unf_set;
    logic          w_int_ovf_set;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_ras_top;
    logic [AW-1:0] w_int_top;

    assign w_int_full = (int_level == LW'(INT_DEPTH));
    assign w_int_nz   = (int_level != '0);
    assign w_int_ack  = int_in & (int_level < LW'(INT_DEPTH));

    // An accepted interrupt swallows br/call/ret for this cycle.
    assign w_ret_ok = ret & ~w_int_ack;
    assign w_taken  = ~w_int_ack & ((br & pnz_hit(cond, r_flags)) | ret);

    // Return targets the interrupt stack while any interrupt is active.
    assign w_int_pop  = w_ret_ok & w_int_nz;
    assign w_ras_pop  = w_ret_ok & ~w_int_nz;
    assign w_ras_push = call & w_taken & ~ret & ~w_int_ack;
    assign w_pc_inc   = pc + AW'(1);

    assign w_ras_ovf_set = w_ras_push & (ras_cnt == CW'(RAS_DEPTH));
    assign w_ras_unf_set = w_ras_pop & (ras_cnt == '0);
    assign w_int_ovf_set = int_in & w_int_full;

    addr_stack #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH),
        .WRAP  (1'b1)
    ) u_ras (
        .clk  (clk),
        .rst  (rst_n),
        .push (w_ras_push),
        .pop  (w_ras_pop),
        .din  (w_pc_inc),
        .top  (w_ras_top),
        .cnt  (ras_cnt)
    );

    addr_stack #(
        .AW    (AW),
        .DEPTH (INT_DEPTH),
        .WRAP  (1'b0)
    ) u_int_stack (
        .clk  (clk),
        .rst  (rst_n),
        .push (w_int_ack),
        .pop  (w_int_pop),
        .din  (pc),
        .top  (w_int_top),
        .cnt  (int_level)
    );

    always_comb begin
        if (ret && w_int_nz) begin
            branch_addr = w_int_top;
        end else if (ret) begin
            // Underflowing return redirects to address zero rather than stale data.
            branch_addr = (ras_cnt == '0) ? '0 : w_ras_top;
        end else begin
            branch_addr = target;
        end
    end

    assign branch_taken = w_taken;
    assign int_ack      = w_int_ack;
    assign ras_ovf      = r_ras_ovf;
    assign ras_unf      = r_ras_unf;
    assign int_ovf      = r_int_ovf;

    // Sticky errors: a new set event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_flags   <= '0;
            r_ras_ovf <= 1'b0;
            r_ras_unf <= 1'b0;
            r_int_ovf <= 1'b0;
        end else begin
            if (flag_we) begin
                r_flags <= pnz_in;
            end
            r_ras_ovf <= w_ras_ovf_set | (r_ras_ovf & ~err_clr);
            r_ras_unf <= w_ras_unf_set | (r_ras_unf & ~err_clr);
            r_int_ovf <= w_int_ovf_set | (r_int_ovf & ~err_clr);
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_branch_unit;

    localparam int AW = 16;
    localparam int RD = 8;
    localparam int ID = 4;
    localparam int CW = $clog2(RD + 1);
    localparam int LW = $clog2(ID + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pc, target;
    logic          br, flag_we, call, ret, int_in, err_clr;
    logic [2:0]    cond, pnz_in;
    logic [AW-1:0] branch_addr;
    logic          branch_taken, int_ack, ras_ovf, ras_unf, int_ovf;
    logic [LW-1:0] int_level;
    logic [CW-1:0] ras_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [AW-1:0] m_ras [$];
    logic [AW-1:0] m_int [$];
    logic [2:0]    m_flags;
    logic          m_ro, m_ru, m_io;

    always #5 clk = ~clk;

    branch_unit #(
        .AW        (AW),
        .RAS_DEPTH (RD),
        .INT_DEPTH (ID)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .target       (target),
        .br           (br),
        .cond         (cond),
        .flag_we      (flag_we),
        .pnz_in       (pnz_in),
        .call         (call),
        .ret          (ret),
        .int_in       (int_in),
        .err_clr      (err_clr),
        .branch_addr  (branch_addr),
        .branch_taken (branch_taken),
        .int_ack      (int_ack),
        .int_level    (int_level),
        .ras_cnt      (ras_cnt),
        .ras_ovf      (ras_ovf),
        .ras_unf      (ras_unf),
        .int_ovf      (int_ovf)
    );

    function automatic void model_comb(output logic ack, output logic tk, output logic [AW-1:0] ad);
        ack = int_in && (m_int.size() < ID);
        tk  = !ack && ((br && ((cond & m_flags) != 3'b000)) || ret);
        if (ret) begin
            if (m_int.size() > 0)      ad = m_int[$];
            else if (m_ras.size() > 0) ad = m_ras[$];
            else                       ad = '0;
        end else begin
            ad = target;
        end
    endfunction

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic step();
        logic ack, tk;
        logic [AW-1:0] ad, ppc;
        logic s_ro, s_ru, s_io, rs, fw, cl, rt, ii, ec;
        logic [2:0] pz;
        model_comb(ack, tk, ad);
        rs = rst_n; fw = flag_we; pz = pnz_in; cl = call; rt = ret;
        ii = int_in; ec = err_clr; ppc = pc;
        s_ro = 1'b0; s_ru = 1'b0; s_io = 1'b0;
        @(posedge clk);
        #1;
        if (rs) begin
            m_ras.delete();
            m_int.delete();
            m_flags = 3'b000;
            m_ro = 1'b0; m_ru = 1'b0; m_io = 1'b0;
        end else begin
            if (fw) m_flags = pz;
            if (ack) begin
                m_int.push_back(ppc);
            end else begin
                if (ii) s_io = 1'b1;
                if (rt) begin
                    if (m_int.size() > 0)      void'(m_int.pop_back());
                    else if (m_ras.size() > 0) void'(m_ras.pop_back());
                    else                       s_ru = 1'b1;
                end else if (cl && tk) begin
                    if (m_ras.size() == RD) begin
                        void'(m_ras.pop_front());
                        s_ro = 1'b1;
                    end
                    m_ras.push_back(ppc + AW'(1));
                end
            end
            m_ro = s_ro | (m_ro & !ec);
            m_ru = s_ru | (m_ru & !ec);
            m_io = s_io | (m_io & !ec);
        end
    endtask

    task automatic clear_in();
        rst_n = 1'b0; pc = '0; target = '0; br = 1'b0; cond = 3'b000;
        flag_we = 1'b0; pnz_in = 3'b000; call = 1'b0; ret = 1'b0;
        int_in = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b1;
        step();
        clear_in();
    endtask

    task automatic set_flags(input logic [2:0] v);
        clear_in();
        flag_we = 1'b1;
        pnz_in  = v;
        step();
        clear_in();
    endtask

    task automatic call_at(input logic [AW-1:0] p);
        clear_in();
        br = 1'b1; cond = 3'b111; call = 1'b1; pc = p; target = 16'h4000;
        step();
        clear_in();
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b1; call = 1'b1; br = 1'b1; cond = 3'b111; int_in = 1'b1; flag_we = 1'b1; pnz_in = 3'b111;
        step();
        clear_in();
        #1;
        n_total++; if (ras_cnt !== '0) begin n_bad++; $display("FAIL reset_ras_cnt got=%0d exp=0", ras_cnt); end
        n_total++; if (int_level !== '0) begin n_bad++; $display("FAIL reset_int_level got=%0d exp=0", int_level); end
        n_total++; if ({ras_ovf, ras_unf, int_ovf} !== 3'b000) begin n_bad++; $display("FAIL reset_sticky got=%b exp=000", {ras_ovf, ras_unf, int_ovf}); end
        br = 1'b1; cond = 3'b111; target = 16'h1111;
        #1;
        n_total++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL reset_flags_taken got=%b exp=0", branch_taken); end
        clear_in();
    endtask

    task automatic test_flags();
        do_reset();
        set_flags(3'b001);
        br = 1'b1; cond = 3'b001; target = 16'h1234;
        #1;
        n_total++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL flags_z_taken got=%b exp=1", branch_taken); end
        n_total++; if (branch_addr !== 16'h1234) begin n_bad++; $display("FAIL flags_z_addr got=%h exp=1234", branch_addr); end
        step();
        cond = 3'b100;
        #1;
        n_total++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL flags_p_nottaken got=%b exp=0", branch_taken); end
        // New flags loaded this cycle must not affect the current decision.
        flag_we = 1'b1; pnz_in = 3'b100;
        #1;
        n_total++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL flags_no_bypass got=%b exp=0", branch_taken); end
        step();
        flag_we = 1'b0;
        #1;
        n_total++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL flags_loaded got=%b exp=1", branch_taken); end
        step();
        clear_in();
    endtask

    task automatic test_nested_calls();
        logic [AW-1:0] exp_a [3];
        exp_a[0] = 16'h0031; exp_a[1] = 16'h0021; exp_a[2] = 16'h0011;
        do_reset();
        set_flags(3'b010);
        for (int i = 1; i <= 3; i++) begin
            call_at(AW'(i * 16));
            n_total++; if (ras_cnt !== CW'(i)) begin n_bad++; $display("FAIL calls_cnt got=%0d exp=%0d", ras_cnt, i); end
        end
        for (int i = 0; i < 3; i++) begin
            ret = 1'b1; target = 16'hBEEF;
            #1;
            n_total++; if (branch_addr !== exp_a[i] || branch_taken !== 1'b1) begin n_bad++; $display("FAIL rets_addr got=%h/%b exp=%h/1", branch_addr, branch_taken, exp_a[i]); end
            step();
            n_total++; if (ras_cnt !== CW'(2 - i)) begin n_bad++; $display("FAIL rets_cnt got=%0d exp=%0d", ras_cnt, 2 - i); end
        end
        clear_in();
    endtask

    task automatic test_ras_ovf_unf();
        do_reset();
        set_flags(3'b001);
        for (int i = 0; i < 9; i++) begin
            call_at(AW'(i));
            if (i == 7) begin
                n_total++; if (ras_ovf !== 1'b0 || ras_cnt !== CW'(8)) begin n_bad++; $display("FAIL ras_full_noovf got=%b/%0d exp=0/8", ras_ovf, ras_cnt); end
            end
        end
        n_total++; if (ras_ovf !== 1'b1 || ras_cnt !== CW'(8)) begin n_bad++; $display("FAIL ras_ovf got=%b/%0d exp=1/8", ras_ovf, ras_cnt); end
        for (int i = 0; i < 8; i++) begin
            ret = 1'b1;
            #1;
            n_total++; if (branch_addr !== AW'(9 - i)) begin n_bad++; $display("FAIL ras_ret_addr got=%h exp=%h", branch_addr, AW'(9 - i)); end
            step();
        end
        ret = 1'b1; target = 16'h5555;
        #1;
        n_total++; if (branch_addr !== '0 || branch_taken !== 1'b1) begin n_bad++; $display("FAIL ras_unf_addr got=%h/%b exp=0000/1", branch_addr, branch_taken); end
        step();
        n_total++; if (ras_unf !== 1'b1 || ras_cnt !== '0) begin n_bad++; $display("FAIL ras_unf got=%b/%0d exp=1/0", ras_unf, ras_cnt); end
        // Underflow again while clearing: set must win for unf, ovf clears.
        err_clr = 1'b1;
        step();
        n_total++; if (ras_unf !== 1'b1 || ras_ovf !== 1'b0) begin n_bad++; $display("FAIL set_wins got=%b%b exp=10", ras_unf, ras_ovf); end
        ret = 1'b0;
        step();
        n_total++; if (ras_unf !== 1'b0 || ras_ovf !== 1'b0) begin n_bad++; $display("FAIL err_clr got=%b%b exp=00", ras_unf, ras_ovf); end
        clear_in();
    endtask

    task automatic test_nested_int();
        do_reset();
        set_flags(3'b100);
        call_at(16'h0050);
        br = 1'b1; cond = 3'b111; call = 1'b1; int_in = 1'b1; pc = 16'h0100;
        #1;
        n_total++; if (int_ack !== 1'b1 || branch_taken !== 1'b0) begin n_bad++; $display("FAIL int1_ack got=%b/%b exp=1/0", int_ack, branch_taken); end
        step();
        n_total++; if (int_level !== LW'(1) || ras_cnt !== CW'(1)) begin n_bad++; $display("FAIL int1_state got=%0d/%0d exp=1/1", int_level, ras_cnt); end
        clear_in();
        int_in = 1'b1; pc = 16'h0200;
        step();
        n_total++; if (int_level !== LW'(2)) begin n_bad++; $display("FAIL int2_level got=%0d exp=2", int_level); end
        clear_in();
        ret = 1'b1;
        #1;
        n_total++; if (branch_addr !== 16'h0200) begin n_bad++; $display("FAIL iret1 got=%h exp=0200", branch_addr); end
        step();
        #1;
        n_total++; if (branch_addr !== 16'h0100) begin n_bad++; $display("FAIL iret2 got=%h exp=0100", branch_addr); end
        step();
        #1;
        n_total++; if (branch_addr !== 16'h0051 || int_level !== '0) begin n_bad++; $display("FAIL iret_ras got=%h/%0d exp=0051/0", branch_addr, int_level); end
        step();
        n_total++; if (ras_cnt !== '0) begin n_bad++; $display("FAIL iret_ras_cnt got=%0d exp=0", ras_cnt); end
        clear_in();
    endtask

    task automatic test_int_sat();
        do_reset();
        for (int i = 0; i < ID; i++) begin
            int_in = 1'b1; pc = AW'(16'h1000 + i * 16);
            #1;
            n_total++; if (int_ack !== 1'b1) begin n_bad++; $display("FAIL sat_ack%0d got=%b exp=1", i, int_ack); end
            step();
        end
        pc = 16'h2000;
        #1;
        n_total++; if (int_ack !== 1'b0) begin n_bad++; $display("FAIL sat_nack got=%b exp=0", int_ack); end
        step();
        n_total++; if (int_ovf !== 1'b1 || int_level !== LW'(ID)) begin n_bad++; $display("FAIL sat_ovf got=%b/%0d exp=1/%0d", int_ovf, int_level, ID); end
        ret = 1'b1;
        #1;
        n_total++; if (int_ack !== 1'b0 || branch_taken !== 1'b1 || branch_addr !== 16'h1030) begin n_bad++; $display("FAIL sat_ret got=%b/%b/%h exp=0/1/1030", int_ack, branch_taken, branch_addr); end
        step();
        n_total++; if (int_level !== LW'(ID - 1)) begin n_bad++; $display("FAIL sat_ret_level got=%0d exp=%0d", int_level, ID - 1); end
        clear_in();
        err_clr = 1'b1;
        step();
        n_total++; if (int_ovf !== 1'b0) begin n_bad++; $display("FAIL int_ovf_clr got=%b exp=0", int_ovf); end
        clear_in();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_flags(3'b111);
        for (int i = 0; i < 3; i++) call_at(AW'(16'h0300 + i));
        for (int i = 0; i < 2; i++) begin
            int_in = 1'b1; pc = AW'(16'h0400 + i);
            step();
        end
        clear_in();
        n_total++; if (ras_cnt !== CW'(3) || int_level !== LW'(2)) begin n_bad++; $display("FAIL mid_pre got=%0d/%0d exp=3/2", ras_cnt, int_level); end
        rst_n = 1'b1; call = 1'b1; br = 1'b1; cond = 3'b111; int_in = 1'b1; pc = 16'h0777;
        step();
        clear_in();
        n_total++; if (ras_cnt !== '0 || int_level !== '0) begin n_bad++; $display("FAIL mid_rst got=%0d/%0d exp=0/0", ras_cnt, int_level); end
        br = 1'b1; cond = 3'b111; ret = 1'b0;
        #1;
        n_total++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL mid_flags got=%b exp=0", branch_taken); end
        br = 1'b0; ret = 1'b1;
        #1;
        n_total++; if (branch_addr !== '0) begin n_bad++; $display("FAIL mid_nopush got=%h exp=0000", branch_addr); end
        step();
        clear_in();
    endtask

    task automatic test_random();
        logic ack, tk;
        logic [AW-1:0] ad;
        for (int n = 0; n < 600; n++) begin
            rst_n   = ($urandom_range(0, 59) == 0);
            pc      = AW'($urandom);
            target  = AW'($urandom);
            br      = $urandom_range(0, 1) == 1;
            cond    = 3'($urandom);
            flag_we = $urandom_range(0, 3) == 0;
            pnz_in  = 3'($urandom);
            call    = $urandom_range(0, 2) != 0;
            ret     = $urandom_range(0, 4) == 0;
            int_in  = $urandom_range(0, 6) == 0;
            err_clr = $urandom_range(0, 15) == 0;
            #1;
            model_comb(ack, tk, ad);
            n_total++; if ({int_ack, branch_taken} !== {ack, tk}) begin n_bad++; $display("FAIL rnd_ctl n=%0d got=%b%b exp=%b%b", n, int_ack, branch_taken, ack, tk); end
            n_total++; if (branch_addr !== ad) begin n_bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, branch_addr, ad); end
            step();
            n_total++; if (ras_cnt !== CW'(m_ras.size()) || int_level !== LW'(m_int.size())) begin n_bad++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, ras_cnt, int_level, m_ras.size(), m_int.size()); end
            n_total++; if ({ras_ovf, ras_unf, int_ovf} !== {m_ro, m_ru, m_io}) begin n_bad++; $display("FAIL rnd_sticky n=%0d got=%b exp=%b", n, {ras_ovf, ras_unf, int_ovf}, {m_ro, m_ru, m_io}); end
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        m_flags = 3'b000; m_ro = 1'b0; m_ru = 1'b0; m_io = 1'b0;
        test_reset();
        test_flags();
        test_nested_calls();
        test_ras_ovf_unf();
        test_nested_int();
        test_int_sat();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
